// File: rtl/seg7_scan_mux.sv
// Scanning driver for a 4-digit common-anode 7-segment display with per-slot
// dead-time blanking, leading-zero suppression and a once-per-frame value latch.
module seg7_scan_mux #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] value_i,
  input  logic        enable_i,
  input  logic        blank_lz_i,
  output logic [6:0]  led_o,
  output logic [3:0]  anode_o,
  output logic        frame_done_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          load_pend_q, load_pend_d;
  logic          loaded_q, loaded_d;
  logic          frame_done_q, frame_done_d;
  logic [6:0]    led_q, led_d;
  logic [3:0]    anode_q, anode_d;

  logic          wrap, load, inBlank, suppressed, lit;
  logic [3:0]    nibble;
  logic [3:0]    zeroFrom;

  function automatic logic [6:0] hexToSeg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // zeroFrom[k] is set when nibbles k..3 of the latched value are all zero
  always_comb begin
    zeroFrom[3] = (shadow_q[15:12] == 4'h0);
    zeroFrom[2] = zeroFrom[3] && (shadow_q[11:8] == 4'h0);
    zeroFrom[1] = zeroFrom[2] && (shadow_q[7:4] == 4'h0);
    zeroFrom[0] = zeroFrom[1] && (shadow_q[3:0] == 4'h0);
  end

  always_comb begin
    wrap         = (cnt_q == CW'(CLK_DIV - 1));
    load         = (wrap && (idx_q == 2'd3)) || load_pend_q;
    cnt_d        = wrap ? '0 : cnt_q + CW'(1);
    idx_d        = wrap ? idx_q + 2'd1 : idx_q;
    shadow_d     = load ? value_i : shadow_q;
    load_pend_d  = 1'b0;
    loaded_d     = load;
    frame_done_d = loaded_q;

    nibble     = shadow_q[{idx_q, 2'b00} +: 4];
    inBlank    = (BLANK_CYCLES != 0) && (cnt_q < CW'(BLANK_CYCLES));
    suppressed = blank_lz_i && (idx_q != 2'd0) && zeroFrom[idx_q];
    lit        = enable_i && !inBlank && !suppressed;

    anode_d = 4'b1111;
    led_d   = 7'b1111111;
    if (lit) begin
      anode_d = ~(4'b0001 << idx_q);
      led_d   = hexToSeg(nibble);
    end
  end

  // frame_done is delayed one extra stage so it lines up with the first
  // registered output cycle of the frame built from the freshly latched value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      load_pend_q  <= 1'b1;
      loaded_q     <= 1'b0;
      frame_done_q <= 1'b0;
      led_q        <= 7'b1111111;
      anode_q      <= 4'b1111;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      load_pend_q  <= load_pend_d;
      loaded_q     <= loaded_d;
      frame_done_q <= frame_done_d;
      led_q        <= led_d;
      anode_q      <= anode_d;
    end
  end

  assign led_o        = led_q;
  assign anode_o      = anode_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with an 8-cycle slot and 2-cycle blank;
// outputs are sampled on the falling edge, inputs are driven there too.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        enable;
  logic        blankLz;
  logic [6:0]  led;
  logic [3:0]  anode;
  logic        frameDone;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] OFF  = 4'b1111;
  localparam logic [6:0] DARK = 7'b1111111;

  always #5 clk = ~clk;

  seg7_scan_mux #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .value_i      (value),
    .enable_i     (enable),
    .blank_lz_i   (blankLz),
    .led_o        (led),
    .anode_o      (anode),
    .frame_done_o (frameDone)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic en, input logic lz);
    value   = v;
    enable  = en;
    blankLz = lz;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] an,
                             input logic [6:0] seg, input logic fd);
    checks++;
    assert (anode === an) else begin
      errors++;
      $error("[TB] FAIL %s anode: got %b, want %b", tag, anode, an);
    end
    checks++;
    assert (led === seg) else begin
      errors++;
      $error("[TB] FAIL %s led: got %b, want %b", tag, led, seg);
    end
    checks++;
    assert (frameDone === fd) else begin
      errors++;
      $error("[TB] FAIL %s frame_done: got %b, want %b", tag, frameDone, fd);
    end
  endtask

  // One full slot: two dead-time cycles then six lit cycles
  task automatic checkSlot(input string tag, input logic [3:0] an,
                           input logic [6:0] seg, input logic fdFirst);
    tick(); checkOutput(tag, OFF, DARK, fdFirst);
    tick(); checkOutput(tag, OFF, DARK, 1'b0);
    repeat (6) begin
      tick(); checkOutput(tag, an, seg, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(16'h1234, 1'b1, 1'b0);

    repeat (3) begin
      tick(); checkOutput("reset", OFF, DARK, 1'b0);
    end
    rst = 1'b0;
    tick(); checkOutput("release1", OFF, DARK, 1'b0);
    tick(); checkOutput("release2_fd", OFF, DARK, 1'b1);
    repeat (6) begin
      tick(); checkOutput("f0_d0", 4'b1110, 7'b0011001, 1'b0);
    end
    checkSlot("f0_d1", 4'b1101, 7'b0110000, 1'b0);
    checkSlot("f0_d2", 4'b1011, 7'b0100100, 1'b0);
    checkSlot("f0_d3", 4'b0111, 7'b1111001, 1'b0);

    checkSlot("f1_d0", 4'b1110, 7'b0011001, 1'b1);
    checkSlot("f1_d1", 4'b1101, 7'b0110000, 1'b0);
    tick(); checkOutput("f1_d2", OFF, DARK, 1'b0);
    tick(); checkOutput("f1_d2", OFF, DARK, 1'b0);
    repeat (3) begin
      tick(); checkOutput("f1_d2", 4'b1011, 7'b0100100, 1'b0);
    end
    applyStimulus(16'hABCD, 1'b1, 1'b0);
    repeat (3) begin
      tick(); checkOutput("f1_d2_tear", 4'b1011, 7'b0100100, 1'b0);
    end
    checkSlot("f1_d3_tear", 4'b0111, 7'b1111001, 1'b0);

    checkSlot("f2_d0", 4'b1110, 7'b0100001, 1'b1);
    checkSlot("f2_d1", 4'b1101, 7'b1000110, 1'b0);
    applyStimulus(16'h0040, 1'b1, 1'b1);
    checkSlot("f2_d2", 4'b1011, 7'b0000011, 1'b0);
    checkSlot("f2_d3", 4'b0111, 7'b0001000, 1'b0);

    checkSlot("lz40_d0", 4'b1110, 7'b1000000, 1'b1);
    checkSlot("lz40_d1", 4'b1101, 7'b0011001, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b1);
    checkSlot("lz40_d2", OFF, DARK, 1'b0);
    checkSlot("lz40_d3", OFF, DARK, 1'b0);

    checkSlot("lz00_d0", 4'b1110, 7'b1000000, 1'b1);
    checkSlot("lz00_d1", OFF, DARK, 1'b0);
    // dropping blank_lz mid-frame exposes the zero digits immediately
    applyStimulus(16'h1234, 1'b1, 1'b0);
    checkSlot("lzoff_d2", 4'b1011, 7'b1000000, 1'b0);
    checkSlot("lzoff_d3", 4'b0111, 7'b1000000, 1'b0);

    checkSlot("f5_d0", 4'b1110, 7'b0011001, 1'b1);
    tick(); checkOutput("f5_d1", OFF, DARK, 1'b0);
    tick(); checkOutput("f5_d1", OFF, DARK, 1'b0);
    tick(); checkOutput("f5_d1", 4'b1101, 7'b0110000, 1'b0);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    repeat (20) begin
      tick(); checkOutput("disabled", OFF, DARK, 1'b0);
    end
    applyStimulus(16'h1234, 1'b1, 1'b0);
    tick(); checkOutput("reenable_d3", 4'b0111, 7'b1111001, 1'b0);

    checkSlot("f6_d0", 4'b1110, 7'b0011001, 1'b1);
    checkSlot("f6_d1", 4'b1101, 7'b0110000, 1'b0);
    tick(); checkOutput("f6_d2", OFF, DARK, 1'b0);
    tick(); checkOutput("f6_d2", OFF, DARK, 1'b0);
    tick(); checkOutput("f6_d2", 4'b1011, 7'b0100100, 1'b0);
    tick(); checkOutput("f6_d2", 4'b1011, 7'b0100100, 1'b0);
    rst = 1'b1;
    applyStimulus(16'hABCD, 1'b1, 1'b0);
    tick(); checkOutput("midrst", OFF, DARK, 1'b0);
    rst = 1'b0;
    tick(); checkOutput("midrst_rel1", OFF, DARK, 1'b0);
    tick(); checkOutput("midrst_rel2_fd", OFF, DARK, 1'b1);
    repeat (6) begin
      tick(); checkOutput("midrst_d0", 4'b1110, 7'b0100001, 1'b0);
    end
    checkSlot("midrst_d1", 4'b1101, 7'b1000110, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
